// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared widths, slot layout, lane ids and writeback bus slicing
// for the in-order retirement stage. Build option COMMIT_PERF_EN (see rob_commit).
`ifndef ROB_COMMIT_PKG_SV
`define ROB_COMMIT_PKG_SV

// Writeback bus slicing: lane l's slot index / 32-bit word on a flat lane bus.
`define WB_POS(bus, l)  bus[(l)*rob_commit_pkg::PTR_W +: rob_commit_pkg::PTR_W]
`define WB_WORD(bus, l) bus[(l)*rob_commit_pkg::DATA_W +: rob_commit_pkg::DATA_W]

package rob_commit_pkg;
  localparam int DEPTH    = 8;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int WB_LANES = 3;
  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int RET_W    = 2;

  localparam int LANE_ALU0 = 0;
  localparam int LANE_ALU1 = 1;
  localparam int LANE_MEM  = 2;

  // Slot layout, msb first: valid, done, we, rd, is_store, is_jump, redirect, data, addr.
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic              is_store;
    logic              is_jump;
    logic              redirect;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] addr;
  } slot_t;

  // Ring pointer advance, wraps mod DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    return p + PTR_W'(n);
  endfunction
endpackage

`endif

// File: rtl/rob_slot.sv
// rob_slot: one reorder slot. Alloc loads the static fields, writeback marks it
// done and latches result/address, clear (retire or flush) drops it.
module rob_slot
  import rob_commit_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       alloc_en,
  input  logic [REG_AW-1:0]          alloc_rd,
  input  logic                       alloc_we,
  input  logic                       alloc_is_store,
  input  logic                       alloc_is_jump,
  input  logic [WB_LANES-1:0]        wb_valid,
  input  logic [WB_LANES*PTR_W-1:0]  wb_pos,
  input  logic [WB_LANES*DATA_W-1:0] wb_data,
  input  logic [WB_LANES*DATA_W-1:0] wb_addr,
  input  logic [WB_LANES-1:0]        wb_redirect,
  input  logic                       clear,
  output slot_t                      slot
);
  localparam logic [PTR_W-1:0] POS = PTR_W'(IDX);

  logic              hit;
  logic              hit_redirect;
  logic [DATA_W-1:0] hit_data;
  logic [DATA_W-1:0] hit_addr;

  // Lane match; scanning upward lets the highest lane naming this slot win.
  always_comb begin
    hit          = 1'b0;
    hit_redirect = 1'b0;
    hit_data     = '0;
    hit_addr     = '0;
    for (int l = LANE_ALU0; l <= LANE_MEM; l++) begin
      if (wb_valid[l] && (`WB_POS(wb_pos, l) == POS)) begin
        hit          = 1'b1;
        hit_redirect = wb_redirect[l];
        hit_data     = `WB_WORD(wb_data, l);
        hit_addr     = `WB_WORD(wb_addr, l);
      end
    end
  end

  // Slot state; clear beats alloc (never both, alloc is refused on flush), writeback needs valid.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slot <= '0;
    end else if (clear) begin
      slot.valid    <= 1'b0;
      slot.done     <= 1'b0;
      slot.redirect <= 1'b0;
    end else if (alloc_en) begin
      slot.valid    <= 1'b1;
      slot.done     <= 1'b0;
      slot.we       <= alloc_we;
      slot.rd       <= alloc_rd;
      slot.is_store <= alloc_is_store;
      slot.is_jump  <= alloc_is_jump;
      slot.redirect <= 1'b0;
      slot.data     <= '0;
      slot.addr     <= '0;
    end else if (slot.valid && hit) begin
      slot.done     <= 1'b1;
      slot.data     <= hit_data;
      slot.addr     <= hit_addr;
      // a mispredict strobe only means something for a branch/jump
      slot.redirect <= hit_redirect & slot.is_jump;
    end
  end
endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement of up to two instructions per cycle, with
// jump-redirect flush. Define COMMIT_PERF_EN to add saturating perf_retired /
// perf_flushes counters.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [PTR_W-1:0]           alloc_pos,
  input  logic [REG_AW-1:0]          alloc_rd,
  input  logic                       alloc_we,
  input  logic                       alloc_is_store,
  input  logic                       alloc_is_jump,
  input  logic [WB_LANES-1:0]        wb_valid,
  input  logic [WB_LANES*PTR_W-1:0]  wb_pos,
  input  logic [WB_LANES*DATA_W-1:0] wb_data,
  input  logic [WB_LANES*DATA_W-1:0] wb_addr,
  input  logic [WB_LANES-1:0]        wb_redirect,
  output logic [RET_W-1:0]           rf_we,
  output logic [RET_W*REG_AW-1:0]    rf_addr,
  output logic [RET_W*DATA_W-1:0]    rf_data,
  output logic                       mem_we,
  output logic [DATA_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  output logic [DEPTH-1:0]           commitbit,
  output logic                       redirect_valid,
  output logic [DATA_W-1:0]          redirect_pc
`ifdef COMMIT_PERF_EN
  ,
  output logic [31:0]                perf_retired,
  output logic [31:0]                perf_flushes
`endif
);
  slot_t             slot_q [DEPTH];
  logic [PTR_W-1:0]  head, tail, head1;
  logic [CNT_W-1:0]  count;
  slot_t             rs     [RET_W];
  logic [PTR_W-1:0]  rpos   [RET_W];
  logic [RET_W-1:0]  ret;
  logic              flush_now, alloc_fire;
  logic [1:0]        n_ret;

  // Retire selection from registered state only.
  assign head1     = ptr_add(head, 2'd1);
  assign rpos[0]   = head;
  assign rpos[1]   = head1;
  assign rs[0]     = slot_q[head];
  assign rs[1]     = slot_q[head1];
  assign ret[0]    = rs[0].valid & rs[0].done;
  // second port: no second store (one memory port), never past a redirect
  assign ret[1]    = ret[0] & rs[1].valid & rs[1].done
                   & ~(rs[0].is_store & rs[1].is_store) & ~rs[0].redirect;
  assign flush_now = (ret[0] & rs[0].redirect) | (ret[1] & rs[1].redirect);
  assign n_ret     = {1'b0, ret[0]} + {1'b0, ret[1]};

  // No bypass: a full queue refuses alloc even while retiring.
  assign alloc_ready = (count < CNT_W'(DEPTH)) & ~flush_now;
  assign alloc_pos   = tail;
  assign alloc_fire  = alloc_valid & alloc_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [PTR_W-1:0] P = PTR_W'(i);
    logic clr;
    // a flush drops every slot: older ones do not exist, retiring ones go anyway
    assign clr = flush_now | (ret[0] && head == P) | (ret[1] && head1 == P);
    rob_slot #(.IDX(i)) u_slot (
      .clk           (clk),
      .nrst          (nrst),
      .alloc_en      (alloc_fire && tail == P),
      .alloc_rd      (alloc_rd),
      .alloc_we      (alloc_we),
      .alloc_is_store(alloc_is_store),
      .alloc_is_jump (alloc_is_jump),
      .wb_valid      (wb_valid),
      .wb_pos        (wb_pos),
      .wb_data       (wb_data),
      .wb_addr       (wb_addr),
      .wb_redirect   (wb_redirect),
      .clear         (clr),
      .slot          (slot_q[i])
    );
  end

  // Ring pointers; a flush collapses the tail onto the post-retire head.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= ptr_add(head, n_ret);
      if (flush_now) begin
        tail  <= ptr_add(head, n_ret);
        count <= '0;
      end else begin
        tail  <= ptr_add(tail, {1'b0, alloc_fire});
        count <= count + CNT_W'(alloc_fire) - CNT_W'(n_ret);
      end
    end
  end

  logic [RET_W-1:0]        rf_we_d;
  logic [RET_W*REG_AW-1:0] rf_addr_d;
  logic [RET_W*DATA_W-1:0] rf_data_d;
  logic                    mem_we_d, rv_d;
  logic [DATA_W-1:0]       mem_addr_d, mem_data_d, rpc_d;
  logic [DEPTH-1:0]        commit_d;

  // Next retire outputs; everything idles at zero when a port does not retire.
  always_comb begin
    rf_we_d    = '0;
    rf_addr_d  = '0;
    rf_data_d  = '0;
    mem_we_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;
    commit_d   = '0;
    rv_d       = 1'b0;
    rpc_d      = '0;
    for (int p = 0; p < RET_W; p++) begin
      if (ret[p]) begin
        commit_d[rpos[p]] = 1'b1;
        if (rs[p].is_store) begin
          mem_we_d   = 1'b1;
          mem_addr_d = rs[p].addr;
          mem_data_d = rs[p].data;
        end else if (rs[p].we) begin
          rf_we_d[p]                      = 1'b1;
          rf_addr_d[p*REG_AW +: REG_AW]   = rs[p].rd;
          rf_data_d[p*DATA_W +: DATA_W]   = rs[p].data;
        end
        if (rs[p].redirect) begin
          rv_d  = 1'b1;
          rpc_d = rs[p].addr;
        end
      end
    end
  end

  // Registered retire outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rf_we          <= '0;
      rf_addr        <= '0;
      rf_data        <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_data       <= '0;
      commitbit      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      rf_we          <= rf_we_d;
      rf_addr        <= rf_addr_d;
      rf_data        <= rf_data_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_data       <= mem_data_d;
      commitbit      <= commit_d;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
    end
  end

`ifdef COMMIT_PERF_EN
  logic [32:0] ret_sum;
  assign ret_sum = {1'b0, perf_retired} + 33'(n_ret);

  // Saturating retire / redirect counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_retired <= '0;
      perf_flushes <= '0;
    end else begin
      perf_retired <= ret_sum[32] ? '1 : ret_sum[31:0];
      if (flush_now && perf_flushes != '1) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: vector table, directed multi-cycle sequences and random traffic
// checked against a program-order queue model of the retirement stage.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  always #5 clk = ~clk;

  logic        alloc_valid, alloc_ready, alloc_we, alloc_is_store, alloc_is_jump;
  logic [2:0]  alloc_pos;
  logic [4:0]  alloc_rd;
  logic [2:0]  wb_valid, wb_redirect;
  logic [8:0]  wb_pos;
  logic [95:0] wb_data, wb_addr;
  logic [1:0]  rf_we;
  logic [9:0]  rf_addr;
  logic [63:0] rf_data;
  logic        mem_we, redirect_valid;
  logic [31:0] mem_addr, mem_data, redirect_pc;
  logic [7:0]  commitbit;
`ifdef COMMIT_PERF_EN
  logic [31:0] perf_retired, perf_flushes;
`endif

  rob_commit dut (
    .clk(clk), .nrst(nrst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pos(alloc_pos),
    .alloc_rd(alloc_rd), .alloc_we(alloc_we), .alloc_is_store(alloc_is_store),
    .alloc_is_jump(alloc_is_jump),
    .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_redirect(wb_redirect),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .commitbit(commitbit), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef COMMIT_PERF_EN
    , .perf_retired(perf_retired), .perf_flushes(perf_flushes)
`endif
  );

  typedef struct packed {
    logic        av;
    logic [4:0]  rd;
    logic        we, st, jmp;
    logic [2:0]  wv, wr;
    logic [8:0]  wp;
    logic [95:0] wd, wa;
  } stim_t;

  typedef struct {
    logic [4:0]  rd;
    logic        we, st, jmp, done, redir;
    logic [31:0] data, addr;
  } ent_t;

  typedef struct {
    stim_t       s;
    logic [1:0]  rfwe;
    logic [9:0]  rfa;
    logic [63:0] rfd;
    logic [7:0]  cb;
  } vec_t;

  ent_t        mq[$];       // in-flight instructions, oldest first
  int          mhead;       // slot index of mq[0]
  int          checks = 0;
  int          errors = 0;
  int unsigned m_ret, m_fl;

  function automatic stim_t nop();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t al(input logic [4:0] rd, input logic we, input logic st, input logic jmp);
    stim_t s = '0;
    s.av = 1'b1; s.rd = rd; s.we = we; s.st = st; s.jmp = jmp;
    return s;
  endfunction

  function automatic stim_t wbl(input stim_t si, input int l, input int pos,
                                input logic [31:0] d, input logic [31:0] a, input logic r);
    stim_t s = si;
    s.wv[l] = 1'b1;
    s.wr[l] = r;
    s.wp[l*3 +: 3]  = 3'(pos);
    s.wd[l*32 +: 32] = d;
    s.wa[l*32 +: 32] = a;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: predict from the model, drive, clock, advance model, compare.
  task automatic step(input stim_t s);
    int n, sz;
    logic fl, rdy, e_mw, e_rv;
    logic [1:0]  e_rfwe;
    logic [9:0]  e_rfa;
    logic [63:0] e_rfd;
    logic [31:0] e_ma, e_md, e_rpc;
    logic [7:0]  e_cb;
    ent_t        e;
    n = 0; fl = 0; e_mw = 0; e_rv = 0; e_rfwe = 0; e_rfa = 0; e_rfd = 0;
    e_ma = 0; e_md = 0; e_rpc = 0; e_cb = 0;
    sz = mq.size();
    if (sz > 0 && mq[0].done) begin
      n = 1;
      if (!mq[0].redir && sz > 1 && mq[1].done && !(mq[0].st && mq[1].st)) n = 2;
    end
    for (int k = 0; k < n; k++) begin
      e_cb[(mhead + k) % 8] = 1'b1;
      if (mq[k].st) begin
        e_mw = 1; e_ma = mq[k].addr; e_md = mq[k].data;
      end else if (mq[k].we) begin
        e_rfwe[k] = 1'b1; e_rfa[k*5 +: 5] = mq[k].rd; e_rfd[k*32 +: 32] = mq[k].data;
      end
      if (mq[k].redir) begin
        fl = 1; e_rv = 1; e_rpc = mq[k].addr;
      end
    end
    rdy = (sz < 8) && !fl;
    chk("alloc_ready", alloc_ready, rdy);
    chk("alloc_pos", alloc_pos, (mhead + sz) % 8);

    alloc_valid = s.av; alloc_rd = s.rd; alloc_we = s.we;
    alloc_is_store = s.st; alloc_is_jump = s.jmp;
    wb_valid = s.wv; wb_pos = s.wp; wb_data = s.wd; wb_addr = s.wa; wb_redirect = s.wr;
    @(posedge clk);
    #1;

    for (int l = 0; l < 3; l++) begin
      if (s.wv[l]) begin
        int idx;
        idx = (int'(s.wp[l*3 +: 3]) - mhead + 8) % 8;
        if (idx < sz) begin
          mq[idx].done  = 1'b1;
          mq[idx].data  = s.wd[l*32 +: 32];
          mq[idx].addr  = s.wa[l*32 +: 32];
          mq[idx].redir = s.wr[l] & mq[idx].jmp;
        end
      end
    end
    if (fl) mq.delete();
    else begin
      repeat (n) void'(mq.pop_front());
      if (s.av && rdy) begin
        e.rd = s.rd; e.we = s.we; e.st = s.st; e.jmp = s.jmp;
        e.done = 0; e.redir = 0; e.data = 0; e.addr = 0;
        mq.push_back(e);
      end
    end
    mhead = (mhead + n) % 8;
    m_ret += n;
    if (fl) m_fl++;

    chk("rf_we", rf_we, e_rfwe);
    chk("rf_addr", rf_addr, e_rfa);
    chk("rf_data", rf_data, e_rfd);
    chk("mem_we", mem_we, e_mw);
    chk("mem_addr", mem_addr, e_ma);
    chk("mem_data", mem_data, e_md);
    chk("commitbit", commitbit, e_cb);
    chk("redirect_valid", redirect_valid, e_rv);
    chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  // Async reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    nrst = 1'b0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_commitbit", commitbit, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_pos", alloc_pos, 0);
    mq.delete(); mhead = 0; m_ret = 0; m_fl = 0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  vec_t tv[9];

  initial begin
    stim_t s;
    s = nop();
    alloc_valid = 0; alloc_rd = 0; alloc_we = 0; alloc_is_store = 0; alloc_is_jump = 0;
    wb_valid = 0; wb_pos = 0; wb_data = 0; wb_addr = 0; wb_redirect = 0;

    tv[0] = '{al(5'd1, 1, 0, 0), 2'b00, 10'd0, 64'd0, 8'h00};
    tv[1] = '{al(5'd2, 1, 0, 0), 2'b00, 10'd0, 64'd0, 8'h00};
    tv[2] = '{al(5'd3, 1, 0, 0), 2'b00, 10'd0, 64'd0, 8'h00};
    tv[3] = '{wbl(wbl(nop(), LANE_ALU0, 0, 32'h11, 0, 0), LANE_ALU1, 1, 32'h22, 0, 0),
              2'b00, 10'd0, 64'd0, 8'h00};
    tv[4] = '{nop(), 2'b11, {5'd2, 5'd1}, {32'h22, 32'h11}, 8'h03};
    tv[5] = '{wbl(wbl(nop(), LANE_ALU0, 2, 32'h99, 0, 0), LANE_MEM, 2, 32'h33, 0, 0),
              2'b00, 10'd0, 64'd0, 8'h00};
    tv[6] = '{nop(), 2'b01, {5'd0, 5'd3}, {32'h0, 32'h33}, 8'h04};
    tv[7] = '{wbl(nop(), LANE_ALU1, 5, 32'h55, 0, 0), 2'b00, 10'd0, 64'd0, 8'h00};
    tv[8] = '{nop(), 2'b00, 10'd0, 64'd0, 8'h00};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tv[i].s);
      chk($sformatf("tv%0d_rf_we", i), rf_we, tv[i].rfwe);
      chk($sformatf("tv%0d_rf_addr", i), rf_addr, tv[i].rfa);
      chk($sformatf("tv%0d_rf_data", i), rf_data, tv[i].rfd);
      chk($sformatf("tv%0d_commitbit", i), commitbit, tv[i].cb);
    end

    // out-of-order completion: youngest done first holds everything back
    do_reset();
    for (int i = 0; i < 3; i++) step(al(5'(4 + i), 1, 0, 0));
    step(wbl(nop(), LANE_ALU0, 2, 32'h2, 0, 0));
    step(nop());
    chk("ooo_hold", commitbit, 8'h00);
    step(wbl(wbl(nop(), LANE_ALU0, 0, 32'h0a, 0, 0), LANE_ALU1, 1, 32'h1b, 0, 0));
    step(nop());
    chk("ooo_pair", commitbit, 8'h03);
    step(nop());
    chk("ooo_last", commitbit, 8'h04);

    // full queue, no bypass on a retiring cycle, tail wrap
    do_reset();
    for (int i = 0; i < 8; i++) step(al(5'(i), 1, 0, 0));
    chk("full_ready", alloc_ready, 0);
    chk("full_pos", alloc_pos, 0);
    step(wbl(wbl(al(5'd9, 1, 0, 0), LANE_ALU0, 0, 32'h1, 0, 0), LANE_ALU1, 1, 32'h2, 0, 0));
    step(al(5'd10, 1, 0, 0));
    chk("full_retire", commitbit, 8'h03);
    chk("after_retire_ready", alloc_ready, 1);
    step(al(5'd11, 1, 0, 0));
    step(al(5'd12, 1, 0, 0));
    chk("wrap_pos", alloc_pos, 2);

    // two adjacent stores share the single memory port
    do_reset();
    step(al(5'd0, 0, 1, 0));
    step(al(5'd0, 0, 1, 0));
    step(wbl(wbl(nop(), LANE_MEM, 0, 32'hAA, 32'h40, 0), LANE_ALU1, 1, 32'hBB, 32'h44, 0));
    step(nop());
    chk("st0_mem_we", mem_we, 1);
    chk("st0_mem_addr", mem_addr, 32'h40);
    chk("st0_rf_we", rf_we, 0);
    step(nop());
    chk("st1_mem_addr", mem_addr, 32'h44);
    chk("st1_commitbit", commitbit, 8'h02);

    // mispredicted jump at slot 1 flushes completed younger slots
    do_reset();
    step(al(5'd1, 1, 0, 0));
    step(al(5'd31, 1, 0, 1));
    for (int i = 0; i < 3; i++) step(al(5'(2 + i), 1, 0, 0));
    step(wbl(wbl(wbl(nop(), LANE_ALU0, 2, 32'h3, 0, 0), LANE_ALU1, 3, 32'h4, 0, 0),
             LANE_MEM, 4, 32'h5, 0, 0));
    step(wbl(wbl(nop(), LANE_ALU0, 0, 32'h7, 0, 0), LANE_ALU1, 1, 32'h8, 32'h100, 1));
    step(al(5'd6, 1, 0, 0));
    chk("jmp_redirect", redirect_valid, 1);
    chk("jmp_pc", redirect_pc, 32'h100);
    chk("jmp_commit", commitbit, 8'h03);
    step(nop());
    chk("jmp_pulse", redirect_valid, 0);
    step(nop());
    step(nop());
    chk("jmp_tail", alloc_pos, 2);
    step(al(5'd7, 1, 0, 0));

    // reset mid-stream with five live slots while outputs are active
    do_reset();
    for (int i = 0; i < 5; i++) step(al(5'(8 + i), 1, 0, 0));
    step(wbl(wbl(nop(), LANE_ALU0, 0, 32'hc0, 0, 0), LANE_ALU1, 1, 32'hc1, 0, 0));
    step(nop());
    chk("pre_reset_commit", commitbit, 8'h03);
    do_reset();
    step(al(5'd13, 1, 0, 0));

    // random traffic against the queue model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      s = nop();
      if ($urandom_range(0, 9) < 7) begin
        int t;
        t = $urandom_range(0, 9);
        s = al(5'($urandom), 1'($urandom), t < 3, t == 3);
      end
      for (int l = 0; l < 3; l++) begin
        if ($urandom_range(0, 1) == 1) begin
          int sz, idx;
          logic r;
          sz = mq.size();
          if (sz > 0 && $urandom_range(0, 4) != 0) begin
            idx = $urandom_range(0, sz - 1);
            r = mq[idx].jmp && ($urandom_range(0, 3) == 0);
            s = wbl(s, l, (mhead + idx) % 8, $urandom, $urandom, r);
          end else begin
            s = wbl(s, l, $urandom_range(0, 7), $urandom, $urandom, 1'b0);
          end
        end
      end
      step(s);
    end
`ifdef COMMIT_PERF_EN
    chk("perf_retired", perf_retired, m_ret);
    chk("perf_flushes", perf_flushes, m_fl);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
